// File: rtl/seq_out_gen.sv
// Purpose: start-triggered sequencer that walks N_OUT channels, channel 0 first,
//          holding each one for a dwell latched when the run is accepted.
// Latency: pattern(0) is registered on the accepting edge. DONE pulses N_OUT*D edges later.
// Backpressure: none. START is only looked at in IDLE and is dropped otherwise (no queuing).
//
// Ports:
//   i_clk       clock, all state on the rising edge
//   i_rst       synchronous active-high reset, overrides START and ABORT
//   i_start     start request, level-sampled while idle
//   i_abort     cancels a running sequence (no DONE pulse)
//   i_dwell     cycles per channel (0 treated as 1), latched on accepted start
//   o_out_sig   registered channel outputs (cumulative or one-hot per MODE)
//   o_busy      registered, high while the sequence is running
//   o_done      registered one-cycle pulse on normal completion
module seq_out_gen #(
    parameter int N_OUT   = 4,
    parameter int DWELL_W = 8,
    parameter int MODE    = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [N_OUT-1:0]   o_out_sig,
    output logic               o_busy,
    output logic               o_done
);

    localparam int CH_W = ($clog2(N_OUT) < 1) ? 1 : $clog2(N_OUT);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_OUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]         r_state;
    logic [CH_W-1:0]    r_ch;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] r_reload;   // D-1, captured at the accepting edge
    logic [N_OUT-1:0]   r_out;
    logic               r_busy;
    logic               r_done;

    logic [DWELL_W-1:0] w_dwell_eff;
    logic [CH_W-1:0]    w_ch_next;

    // A zero dwell would never let the counter expire, so it is promoted to 1.
    assign w_dwell_eff = (i_dwell == '0) ? DWELL_W'(1) : i_dwell;
    assign w_ch_next   = r_ch + CH_W'(1);

    function automatic logic [N_OUT-1:0] pattern(input logic [CH_W-1:0] ch);
        logic [N_OUT-1:0] pat;
        pat = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (MODE == 0) begin
                pat[i] = (i <= int'(ch));
            end else begin
                pat[i] = (i == int'(ch));
            end
        end
        return pat;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_ch     <= '0;
            r_cnt    <= '0;
            r_reload <= '0;
            r_out    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_out  <= '0;
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                    if (i_start && !i_abort) begin
                        r_state  <= S_RUN;
                        r_ch     <= '0;
                        r_cnt    <= w_dwell_eff - DWELL_W'(1);
                        r_reload <= w_dwell_eff - DWELL_W'(1);
                        r_out    <= pattern('0);
                        r_busy   <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (i_abort) begin
                        // Abort wins over channel advance and over completion.
                        r_state <= S_IDLE;
                        r_ch    <= '0;
                        r_cnt   <= '0;
                        r_out   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - DWELL_W'(1);
                    end else if (r_ch != LAST_CH) begin
                        r_ch  <= w_ch_next;
                        r_cnt <= r_reload;
                        r_out <= pattern(w_ch_next);
                    end else begin
                        r_state <= S_FIN;
                        r_ch    <= '0;
                        r_out   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_FIN: begin
                    // Single-cycle state; START and ABORT are both ignored here.
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ch    <= '0;
                    r_cnt   <= '0;
                    r_out   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_out_sig = r_out;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule

// File: tb/tb_seq_out_gen.sv
module tb_seq_out_gen;

    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] dwell = '0;

    logic [N-1:0]  out0, out1;
    logic          busy0, busy1, done0, done1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    seq_out_gen #(.N_OUT(N), .DWELL_W(DW), .MODE(0)) u_cum (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_dwell(dwell),
        .o_out_sig(out0), .o_busy(busy0), .o_done(done0)
    );

    seq_out_gen #(.N_OUT(N), .DWELL_W(DW), .MODE(1)) u_hot (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_dwell(dwell),
        .o_out_sig(out1), .o_busy(busy1), .o_done(done1)
    );

    // Timeline model: a run is described by edges elapsed since acceptance (m_t)
    // and the dwell D; the visible channel is m_t / D.
    bit m_active = 1'b0;
    bit m_fin    = 1'b0;
    int m_t      = 0;
    int m_d      = 1;

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_fin    <= 1'b0;
            m_t      <= 0;
        end else if (m_fin) begin
            m_fin <= 1'b0;
        end else if (m_active) begin
            if (abort) begin
                m_active <= 1'b0;
            end else if (m_t + 1 == N * m_d) begin
                m_active <= 1'b0;
                m_fin    <= 1'b1;
            end else begin
                m_t <= m_t + 1;
            end
        end else if (start && !abort) begin
            m_active <= 1'b1;
            m_t      <= 0;
            m_d      <= (dwell == '0) ? 1 : int'(dwell);
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            int idx;
            logic [N-1:0] e0, e1;
            logic eb, ed;
            e0 = '0; e1 = '0; eb = 1'b0; ed = 1'b0;
            if (m_active) begin
                idx = m_t / m_d;
                e0  = N'((1 << (idx + 1)) - 1);
                e1  = N'(1 << idx);
                eb  = 1'b1;
            end else begin
                ed = m_fin;
            end
            cmp("cycle_out_cum", int'(out0), int'(e0));
            cmp("cycle_out_hot", int'(out1), int'(e1));
            cmp("cycle_busy_cum", int'(busy0), int'(eb));
            cmp("cycle_busy_hot", int'(busy1), int'(eb));
            cmp("cycle_done_cum", int'(done0), int'(ed));
            cmp("cycle_done_hot", int'(done1), int'(ed));
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int rises[$];
    bit prev_busy;

    initial begin
        // Reset
        tick(2);
        chk_en = 1'b1;
        cmp("rst_out", int'(out0), 0);
        cmp("rst_busy", int'(busy0), 0);
        cmp("rst_done", int'(done0), 0);
        rst = 1'b0;
        tick(3);

        // 1: cumulative, DWELL=1
        dwell = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        cmp("t1_p0", int'(out0), 4'b0001);
        cmp("t1_busy", int'(busy0), 1);
        tick(); cmp("t1_p1", int'(out0), 4'b0011);
        tick(); cmp("t1_p2", int'(out0), 4'b0111);
        tick(); cmp("t1_p3", int'(out0), 4'b1111);
        cmp("t1_p3_hot", int'(out1), 4'b1000);
        tick();
        cmp("t1_fin_out", int'(out0), 0);
        cmp("t1_fin_done", int'(done0), 1);
        cmp("t1_fin_busy", int'(busy0), 0);
        tick(); cmp("t1_done_drop", int'(done0), 0);
        tick(2);

        // 2: one-hot, DWELL=3, dwell change mid-run ignored
        dwell = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        cmp("t2_p0", int'(out1), 4'b0001);
        tick(3); cmp("t2_p1", int'(out1), 4'b0010);
        dwell = 8'd7;
        tick(3); cmp("t2_p2", int'(out1), 4'b0100);
        cmp("t2_p2_cum", int'(out0), 4'b0111);
        tick(5); cmp("t2_p3_end", int'(out1), 4'b1000);
        cmp("t2_no_done", int'(done1), 0);
        tick(); cmp("t2_done", int'(done1), 1);
        cmp("t2_fin_out", int'(out1), 0);
        tick(); cmp("t2_done_drop", int'(done1), 0);
        tick(2);

        // 3: DWELL=0 behaves as 1
        dwell = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        cmp("t3_p0", int'(out0), 4'b0001);
        tick(3); cmp("t3_p3", int'(out0), 4'b1111);
        tick(); cmp("t3_done", int'(done0), 1);
        tick(3);

        // 4: abort at ch=2, then abort together with start in idle
        dwell = 8'd2; start = 1'b1;
        tick();
        start = 1'b0;
        tick(4); cmp("t4_ch2", int'(out0), 4'b0111);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        cmp("t4_abort_out", int'(out0), 0);
        cmp("t4_abort_busy", int'(busy0), 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            cmp("t4_no_done", int'(done0 | done1), 0);
        end
        abort = 1'b1; start = 1'b1;
        tick(2);
        cmp("t4_as_busy", int'(busy0), 0);
        cmp("t4_as_out", int'(out0), 0);
        abort = 1'b0; start = 1'b0;
        tick(2);

        // 5: START held high, runs start every N*D+2 = 6 cycles
        dwell = 8'd1; start = 1'b1;
        prev_busy = busy0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (busy0 && !prev_busy) rises.push_back(i);
            prev_busy = busy0;
        end
        start = 1'b0;
        cmp("t5_runs", rises.size(), 5);
        for (int i = 0; i < rises.size(); i++) begin
            cmp("t5_rise_at", rises[i], 1 + 6 * i);
        end
        tick(8);

        // 6: reset mid-run, reset with start
        dwell = 8'd2; start = 1'b1;
        tick();
        start = 1'b0;
        tick(2); cmp("t6_ch1", int'(out0), 4'b0011);
        rst = 1'b1;
        tick();
        cmp("t6_rst_out", int'(out0), 0);
        cmp("t6_rst_busy", int'(busy0), 0);
        start = 1'b1;
        tick();
        cmp("t6_rst_start_busy", int'(busy0), 0);
        cmp("t6_rst_start_out", int'(out1), 0);
        rst = 1'b0; start = 1'b0;
        tick(3);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
